if_fetch_ctrl: RTL
==================

Name: if_fetch_ctrl

Overview:
- Fetch-stage sequencer that owns the program counter and drives the instruction memory, one request at a time.
- Holds fetched words in a 2-entry prefetch buffer, so a decode freeze never loses or re-fetches an instruction.
- On a branch it redirects the PC, flushes the buffer and discards any stale in-flight word.
- Sits between InstructionMem (or a multi-cycle replacement) and the IF/ID pipeline register.

Parameters:
- ADDR_W, 32, PC and address width.
- RESET_PC, 32'h00000000, PC value after reset.
- PC_STEP, 4, byte increment per sequential fetch.
- BUF_DEPTH, 2, prefetch buffer entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  memory accepts the request and returns imem_rdata this cycle; tie high for a combinational memory.
- imem_rdata  in  32  fetched instruction; sampled only when imem_req&imem_ready.
- branch_taken  in  1  redirect request from EX, single-cycle pulse.
- branch_addr  in  ADDR_W  redirect target.
- if_ready  in  1  IF/ID can accept, equal to ~freeze.
- if_valid  out  1  buffer head valid.
- if_instr  out  32  buffer head instruction.
- if_pc  out  ADDR_W  buffer head fetch address + PC_STEP (ARM PC+4 convention).

Behaviour:
- Reset (rst=0 at an edge):
  - pc=RESET_PC, count=0, read and write pointers=0, state=IDLE.
  - imem_req=0, if_valid=0; if_instr and if_pc read 0 while empty.
  - Reset mid-request abandons the request with no hold obligation.
- States:
  - IDLE: req=0. Go to FETCH on the first cycle with rst=1.
  - FETCH: req=1 while count+1<=BUF_DEPTH, i.e. there is space for the response. imem_addr=pc.
  - DROP: req=1 with imem_addr=stale_addr held until imem_ready.
- FETCH response (req&ready, no branch):
  - Write {pc, rdata} at the write pointer; count+1; pc=pc+PC_STEP, modulo 2^ADDR_W.
  - The next request issues the following cycle if space remains.
- Throughput and latency:
  - Combinational memory with if_ready=1 sustains 1 instruction per cycle.
  - First if_valid appears 2 cycles after rst deasserts: cycle 1 is IDLE, cycle 2 fetches, cycle 3 shows valid.
- Buffer full: req=0. Hold until a pop frees an entry, then request the next cycle.
- Push and pop in the same cycle: count is unchanged. This is legal when full, because the pop is evaluated with the push.
- Pop: occurs when if_valid&if_ready. Advances the read pointer; count-1.
- if_valid=1 with if_ready=0: if_instr and if_pc remain stable.
- Branch (branch_taken=1) has priority over push and pop in that cycle:
  - count=0, both pointers reset, pc=branch_addr; if_valid=0 next cycle.
  - If a request is outstanding and imem_ready=0: latch stale_addr=imem_addr, go to DROP.
  - In DROP, when ready arrives, discard the data and go to FETCH with imem_addr=branch_addr.
  - If imem_ready=1 in the branch cycle: discard the data and stay in FETCH.
  - Branch while frozen (if_ready=0): still taken.
  - Branch during DROP: update pc to the new target; stale_addr is unchanged.
- Protocol rule: once raised, imem_req never drops and imem_addr never changes before imem_ready, except on reset.
- imem_rdata is never interpreted, so X/Z contents from unmapped addresses are passed through unchecked.

Decomposition:
- Shared package if_pkg:
  - ADDR_W, RESET_PC, PC_STEP.
  - Fetch state encoding {IDLE, FETCH, DROP}.
  - Buffer entry typedef {pc, instr}.
- One sub-module, if_prefetch_buf: parameterised FIFO with synchronous flush, simultaneous push/pop, count, full and empty.
- The PC and FSM stay in the top.

Test Plan:
- Reset release, imem_ready=1, if_ready=1, memory loaded with the MOV/ADDS/ADC program -> imem_addr 0,4,8,C on consecutive cycles; if_pc 4,8,C,10; if_instr 0xE3A00014 first.
- if_ready=0 for 5 cycles after the 2nd word -> buffer fills with words 2 and 3 and imem_req drops. On release: addresses 0x8, 0xC pop in order with no gap and no duplicate, then a request for 0x10.
- imem_ready delayed 3 cycles per fetch -> imem_addr held constant across each wait; one if_valid per accepted response.
- branch_taken with branch_addr=0x40 while a 0x14 request waits 2 cycles -> state DROP; the 0x14 data is discarded; next request is 0x40; if_pc=0x44 on the first valid.
- branch_taken coincident with push and pop while the buffer is full -> buffer empty next cycle; no pre-branch word ever appears on if_instr.
- rst=0 for one cycle mid-DROP -> all outputs reset next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared fetch-stage constants, FSM encoding and prefetch buffer entry type.
package if_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } buf_entry_t;

endpackage

// File: rtl/if_prefetch_buf.sv
// Small FIFO of fetched words with synchronous flush and same-cycle push/pop.
module if_prefetch_buf
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  buf_entry_t             push_data,
    input  logic                   pop,
    output buf_entry_t             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    buf_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot the same-cycle push uses, so push is legal when full.
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy update; flush wins over push and pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request at a time, buffers words
// for decode and discards the in-flight word after a branch redirect.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               if_ready,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] stale_q;
    logic [ADDR_W-1:0] stale_d;

    logic              buf_push;
    logic              buf_pop;
    logic              buf_flush;
    logic              buf_full;
    logic              buf_empty;
    logic [CNT_W-1:0]  buf_count;
    buf_entry_t        push_entry;
    buf_entry_t        head_entry;

    assign push_entry = '{pc: pc_q, instr: imem_rdata};

    if_prefetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (buf_flush),
        .push      (buf_push),
        .push_data (push_entry),
        .pop       (buf_pop),
        .head      (head_entry),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // Head of buffer drives decode; fields read zero while empty.
    assign if_valid = (buf_count != '0);
    assign if_instr = buf_empty ? '0 : head_entry.instr;
    assign if_pc    = buf_empty ? '0 : head_entry.pc + PC_STEP;
    assign buf_pop  = if_valid & if_ready & ~branch_taken;

    // State, PC and stale-address registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            stale_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
        end
    end

    // Next-state, request and buffer control; branch overrides push/pop and PC.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stale_d   = stale_q;
        imem_req  = 1'b0;
        imem_addr = pc_q;
        buf_push  = 1'b0;
        buf_flush = branch_taken;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = ~buf_full;
                if (branch_taken) begin
                    // Outstanding request must stay on the bus until accepted.
                    if (!buf_full && !imem_ready) begin
                        stale_d = pc_q;
                        state_d = DROP;
                    end
                end else if (!buf_full && imem_ready) begin
                    buf_push = 1'b1;
                    pc_d     = pc_q + PC_STEP;
                end
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = stale_q;
                if (imem_ready) state_d = FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (branch_taken) pc_d = branch_addr;
    end

endmodule
